// File: rtl/gtxe2_comm_qpll_lockdet.sv
// Measured frequency-lock detector for the QPLL model: counts toggle edges of the
// divided ref/fb clocks over fixed windows and runs a hysteretic lock state machine.
module gtxe2_comm_qpll_lockdet #(
    parameter int WIN_LEN        = 256,
    parameter int CNT_W          = 12,
    parameter int RATIO_NUM      = 2,
    parameter int RATIO_DEN      = 1,
    parameter int TOL            = 4,
    parameter int LOCK_WINDOWS   = 3,
    parameter int UNLOCK_WINDOWS = 2
) (
    input  logic             QPLLLOCKDETCLK,
    input  logic             QPLLRESET,
    input  logic             QPLLPD,
    input  logic             QPLLLOCKEN,
    input  logic             ref_tgl,
    input  logic             fb_tgl,
    output logic             QPLLLOCK,
    output logic             QPLLREFCLKLOST,
    output logic             QPLLFBCLKLOST,
    output logic [CNT_W-1:0] ref_cnt_last,
    output logic [CNT_W-1:0] fb_cnt_last,
    output logic [1:0]       lock_state
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int PW    = CNT_W + 16;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [3:0]       GOOD_LAST = 4'(LOCK_WINDOWS - 1);
    localparam logic [3:0]       BAD_LAST  = 4'(UNLOCK_WINDOWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    logic             srst;
    logic [1:0]       tgl_in;
    logic [WIN_W-1:0] win_cnt_q;
    logic             win_end;
    logic             eval_q;
    logic [CNT_W-1:0] cnt_last_w [2];

    assign srst    = QPLLRESET | QPLLPD;
    assign tgl_in  = {fb_tgl, ref_tgl};
    assign win_end = (win_cnt_q == WIN_LAST);

    always_ff @(posedge QPLLLOCKDETCLK) begin
        if (srst) begin
            win_cnt_q <= '0;
            eval_q    <= 1'b0;
        end else begin
            win_cnt_q <= win_end ? '0 : win_cnt_q + WIN_W'(1);
            eval_q    <= win_end;
        end
    end

    // Channel 0 = ref, channel 1 = fb. The edge seen in the last window cycle is
    // folded into the latched count so no edge is lost across the boundary.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_q;
            logic             sync2_q;
            logic             hist_q;
            logic             edge_det;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_last_q;
            logic [CNT_W-1:0] cnt_sum;

            assign edge_det = sync2_q ^ hist_q;
            assign cnt_sum  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(edge_det);

            always_ff @(posedge QPLLLOCKDETCLK) begin
                if (srst) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    hist_q     <= 1'b0;
                    cnt_q      <= '0;
                    cnt_last_q <= '0;
                end else begin
                    sync1_q <= tgl_in[gi];
                    sync2_q <= sync1_q;
                    hist_q  <= sync2_q;
                    if (win_end) begin
                        cnt_last_q <= cnt_sum;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_sum;
                    end
                end
            end

            assign cnt_last_w[gi] = cnt_last_q;
        end
    endgenerate

    assign ref_cnt_last = cnt_last_w[0];
    assign fb_cnt_last  = cnt_last_w[1];

    logic [PW-1:0]   fb_prod;
    logic [PW-1:0]   ref_prod;
    logic signed [PW:0] diff;
    logic [PW:0]     diff_mag;
    logic            ref_zero;
    logic            fb_zero;
    logic            ref_lost_now;
    logic            fb_lost_now;
    logic            good_win;

    assign fb_prod      = PW'(fb_cnt_last) * PW'(RATIO_DEN);
    assign ref_prod     = PW'(ref_cnt_last) * PW'(RATIO_NUM);
    assign diff         = $signed({1'b0, fb_prod}) - $signed({1'b0, ref_prod});
    assign diff_mag     = diff[PW] ? $unsigned(-diff) : $unsigned(diff);
    assign ref_zero     = (ref_cnt_last == '0);
    assign fb_zero      = (fb_cnt_last == '0);
    assign ref_lost_now = ref_zero;
    assign fb_lost_now  = !ref_zero && fb_zero;
    assign good_win     = !ref_zero && !fb_zero && (diff_mag <= (PW+1)'(TOL));

    logic ref_lost_q;
    logic fb_lost_q;

    // Loss flags track every window even while lock detection is disabled.
    always_ff @(posedge QPLLLOCKDETCLK) begin
        if (srst) begin
            ref_lost_q <= 1'b0;
            fb_lost_q  <= 1'b0;
        end else if (eval_q) begin
            ref_lost_q <= ref_lost_now;
            fb_lost_q  <= fb_lost_now;
        end
    end

    state_t     state_q, state_d;
    logic [3:0] good_run_q, good_run_d;
    logic [3:0] bad_run_q, bad_run_d;

    always_ff @(posedge QPLLLOCKDETCLK) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            good_run_q <= '0;
            bad_run_q  <= '0;
        end else begin
            state_q    <= state_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        if (!QPLLLOCKEN) begin
            state_d = ST_IDLE;
        end else if (eval_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ACQ;
                    good_run_d = '0;
                    bad_run_d  = '0;
                end
                ST_ACQ: begin
                    if (!good_win) begin
                        good_run_d = '0;
                    end else if (good_run_q == GOOD_LAST) begin
                        state_d    = ST_LOCKED;
                        good_run_d = '0;
                        bad_run_d  = '0;
                    end else begin
                        good_run_d = good_run_q + 4'd1;
                    end
                end
                ST_LOCKED: begin
                    // A vanished clock drops lock at once; ratio errors need a run.
                    if (ref_lost_now || fb_lost_now || (!good_win && bad_run_q == BAD_LAST)) begin
                        state_d    = ST_ACQ;
                        good_run_d = '0;
                        bad_run_d  = '0;
                    end else if (good_win) begin
                        bad_run_d = '0;
                    end else begin
                        bad_run_d = bad_run_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        QPLLLOCK       = (state_q == ST_LOCKED);
        QPLLREFCLKLOST = ref_lost_q;
        QPLLFBCLKLOST  = fb_lost_q;
        lock_state     = state_q;
    end

endmodule
